parking_fee_calc: RTL and testbench

Per-slot occupancy tracker and fee calculator that consumes the free-running 11-bit tick count from `time_counter`. On car entry it latches the current tick count for that slot. On car exit it computes the elapsed ticks, modulo 2^11, and converts them to a fee by iterative subtraction. It sits between the gate sensors and the display/payment logic.

---
 rtl/parking_pkg.sv | 16 +
 rtl/parking_fee_calc_if.sv | 36 +++
 rtl/fee_divider.sv | 89 ++++++++
 rtl/parking_fee_calc.sv | 99 +++++++++
 tb/tb_parking_fee_calc.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking fee calculator slice.
package parking_pkg;

    localparam int unsigned TIMER_W              = 11;
    localparam int unsigned NUM_SLOTS_DEF        = 4;
    localparam int unsigned TICKS_PER_UNIT_DEF   = 60;
    localparam int unsigned RATE_DEF             = 10;
    localparam int unsigned GRACE_DEF            = 15;
    localparam int unsigned FEE_W_DEF            = 16;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/parking_fee_calc_if.sv
// Event inputs and occupancy/fee outputs of the parking fee calculator.
interface parking_fee_calc_if
    import parking_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int unsigned FEE_W     = FEE_W_DEF
);
    localparam int unsigned ID_W  = $clog2(NUM_SLOTS);
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

    logic [TIMER_W-1:0]   i_timer;
    logic                 i_car_in;
    logic                 i_car_out;
    logic [ID_W-1:0]      i_slot_id;
    logic [NUM_SLOTS-1:0] o_occupied;
    logic [CNT_W-1:0]     o_free_count;
    logic                 o_full;
    logic                 o_busy;
    logic [FEE_W-1:0]     o_fee;
    logic [ID_W-1:0]      o_fee_slot;
    logic                 o_fee_valid;
    logic                 o_err;

    modport slave (
        input  i_timer, i_car_in, i_car_out, i_slot_id,
        output o_occupied, o_free_count, o_full, o_busy,
        output o_fee, o_fee_slot, o_fee_valid, o_err
    );

    modport master (
        output i_timer, i_car_in, i_car_out, i_slot_id,
        input  o_occupied, o_free_count, o_full, o_busy,
        input  o_fee, o_fee_slot, o_fee_valid, o_err
    );

endinterface

// File: rtl/fee_divider.sv
// Turns an elapsed tick count into a fee by repeated subtraction of one
// billable unit per clock, carrying the slot tag through to the result.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one unit consumed per edge; result published when remainder is 0
module fee_divider
    import parking_pkg::*;
#(
    parameter int unsigned TICKS_PER_UNIT = TICKS_PER_UNIT_DEF,
    parameter int unsigned RATE           = RATE_DEF,
    parameter int unsigned GRACE          = GRACE_DEF,
    parameter int unsigned FEE_W          = FEE_W_DEF,
    parameter int unsigned TAG_W          = 2
)(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [TIMER_W-1:0] i_dur,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_busy,
    output logic               o_done,
    output logic [FEE_W-1:0]   o_fee,
    output logic [TAG_W-1:0]   o_tag
);
    localparam logic [FEE_W-1:0]   FEE_MAX = '1;
    localparam logic [TIMER_W-1:0] UNIT    = TIMER_W'(TICKS_PER_UNIT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TIMER_W-1:0] r_rem;
    logic [FEE_W-1:0]   r_acc;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        w_sum;
    logic [FEE_W-1:0]   w_acc_sat;

    // Saturating accumulate; done in 32 bits so a RATE wider than the fee still clamps.
    always_comb begin
        w_sum     = 32'(r_acc) + RATE;
        w_acc_sat = (w_sum > 32'(FEE_MAX)) ? FEE_MAX : w_sum[FEE_W-1:0];
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = CALC;
            CALC:    if (r_rem == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Remainder/accumulator datapath and result registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rem  <= '0;
            r_acc  <= '0;
            r_tag  <= '0;
            o_fee  <= '0;
            o_tag  <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (r_state == IDLE) begin
                if (i_start) begin
                    r_rem <= (32'(i_dur) <= GRACE) ? '0 : i_dur;
                    r_acc <= '0;
                    r_tag <= i_tag;
                end
            end else if (r_rem == '0) begin
                o_fee  <= r_acc;
                o_tag  <= r_tag;
                o_done <= 1'b1;
            end else begin
                r_acc <= w_acc_sat;
                r_rem <= (r_rem >= UNIT) ? r_rem - UNIT : '0;
            end
        end
    end

    assign o_busy = (r_state == CALC);

endmodule

// File: rtl/parking_fee_calc.sv
// Slot occupancy tracking with entry time stamps; exits hand the elapsed
// tick count to fee_divider. Illegal events only raise a one-cycle err.
module parking_fee_calc
    import parking_pkg::*;
#(
    parameter int unsigned NUM_SLOTS      = NUM_SLOTS_DEF,
    parameter int unsigned TICKS_PER_UNIT = TICKS_PER_UNIT_DEF,
    parameter int unsigned RATE           = RATE_DEF,
    parameter int unsigned GRACE          = GRACE_DEF,
    parameter int unsigned FEE_W          = FEE_W_DEF
)(
    input logic               i_clk,
    input logic               i_reset,
    parking_fee_calc_if.slave bus
);
    localparam int unsigned ID_W  = $clog2(NUM_SLOTS);
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

    logic [NUM_SLOTS-1:0] r_occupied;
    logic [NUM_SLOTS-1:0] w_occ_nxt;
    logic [TIMER_W-1:0]   r_entry [NUM_SLOTS];
    logic [CNT_W-1:0]     r_free_count;
    logic                 r_full;
    logic                 r_err;
    logic                 w_id_ok;
    logic                 w_occ_sel;
    logic                 w_event;
    logic                 w_acc_in;
    logic                 w_acc_out;
    logic                 w_busy;
    logic [TIMER_W-1:0]   w_dur;

    function automatic logic [CNT_W-1:0] count_free(input logic [NUM_SLOTS-1:0] occ);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++)
            if (!occ[i]) n = n + CNT_W'(1);
        return n;
    endfunction

    // Event qualification: only one event at a time, in-range slot, idle divider.
    always_comb begin
        w_id_ok   = (32'(bus.i_slot_id) < NUM_SLOTS);
        w_occ_sel = w_id_ok ? r_occupied[bus.i_slot_id] : 1'b0;
        w_event   = bus.i_car_in | bus.i_car_out;
        w_acc_in  = bus.i_car_in & ~bus.i_car_out & ~w_busy & w_id_ok & ~w_occ_sel;
        w_acc_out = bus.i_car_out & ~bus.i_car_in & ~w_busy & w_id_ok & w_occ_sel;
        w_dur     = bus.i_timer - r_entry[bus.i_slot_id];
    end

    // Occupancy after this edge, so free_count/full can be registered alongside it.
    always_comb begin
        w_occ_nxt = r_occupied;
        if (w_acc_in)  w_occ_nxt[bus.i_slot_id] = 1'b1;
        if (w_acc_out) w_occ_nxt[bus.i_slot_id] = 1'b0;
    end

    // Slot state, entry stamps and error pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_occupied   <= '0;
            r_free_count <= CNT_W'(NUM_SLOTS);
            r_full       <= 1'b0;
            r_err        <= 1'b0;
            for (int i = 0; i < int'(NUM_SLOTS); i++) r_entry[i] <= '0;
        end else begin
            r_occupied   <= w_occ_nxt;
            r_free_count <= count_free(w_occ_nxt);
            r_full       <= &w_occ_nxt;
            r_err        <= w_event & ~(w_acc_in | w_acc_out);
            if (w_acc_in) r_entry[bus.i_slot_id] <= bus.i_timer;
        end
    end

    fee_divider #(
        .TICKS_PER_UNIT (TICKS_PER_UNIT),
        .RATE           (RATE),
        .GRACE          (GRACE),
        .FEE_W          (FEE_W),
        .TAG_W          (ID_W)
    ) u_fee_divider (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (w_acc_out),
        .i_dur   (w_dur),
        .i_tag   (bus.i_slot_id),
        .o_busy  (w_busy),
        .o_done  (bus.o_fee_valid),
        .o_fee   (bus.o_fee),
        .o_tag   (bus.o_fee_slot)
    );

    assign bus.o_occupied   = r_occupied;
    assign bus.o_free_count = r_free_count;
    assign bus.o_full       = r_full;
    assign bus.o_busy       = w_busy;
    assign bus.o_err        = r_err;

endmodule

// File: tb/tb_parking_fee_calc.sv
// Directed bench: default 4-slot instance plus a 5-slot, 4-bit-fee instance
// used for out-of-range slot ids and fee saturation.
module tb_parking_fee_calc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    parking_fee_calc_if #(.NUM_SLOTS(4), .FEE_W(16)) bus ();
    parking_fee_calc_if #(.NUM_SLOTS(5), .FEE_W(4))  bus5 ();

    parking_fee_calc #(.NUM_SLOTS(4), .TICKS_PER_UNIT(60), .RATE(10), .GRACE(15), .FEE_W(16)) u_dut (
        .i_clk(clk), .i_reset(rst), .bus(bus.slave));

    parking_fee_calc #(.NUM_SLOTS(5), .TICKS_PER_UNIT(60), .RATE(10), .GRACE(15), .FEE_W(4)) u_dut5 (
        .i_clk(clk), .i_reset(rst), .bus(bus5.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic cin, input logic cout, input logic [1:0] id, input logic [10:0] t);
        bus.i_car_in = cin; bus.i_car_out = cout; bus.i_slot_id = id; bus.i_timer = t;
        tick();
        bus.i_car_in = 1'b0; bus.i_car_out = 1'b0;
    endtask

    task automatic ev5(input logic cin, input logic cout, input logic [2:0] id, input logic [10:0] t);
        bus5.i_car_in = cin; bus5.i_car_out = cout; bus5.i_slot_id = id; bus5.i_timer = t;
        tick();
        bus5.i_car_in = 1'b0; bus5.i_car_out = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        checks++; if (bus.o_occupied !== 4'b0000) begin errors++; $display("FAIL reset_occ got %b exp 0000", bus.o_occupied); end
        checks++; if (bus.o_free_count !== 3'd4) begin errors++; $display("FAIL reset_free got %0d exp 4", bus.o_free_count); end
        checks++; if (bus.o_full !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_err !== 1'b0 || bus.o_fee_valid !== 1'b0) begin
            errors++; $display("FAIL reset_flags got full=%b busy=%b err=%b fv=%b exp all 0", bus.o_full, bus.o_busy, bus.o_err, bus.o_fee_valid); end
        checks++; if (bus.o_fee !== 16'd0 || bus.o_fee_slot !== 2'd0) begin
            errors++; $display("FAIL reset_fee got fee=%0d slot=%0d exp 0/0", bus.o_fee, bus.o_fee_slot); end
        checks++; if (bus5.o_free_count !== 3'd5) begin errors++; $display("FAIL reset_free5 got %0d exp 5", bus5.o_free_count); end
    endtask

    task automatic test_basic_fee();
        int bc;
        ev(1, 0, 2'd2, 11'd100);
        checks++; if (bus.o_occupied !== 4'b0100 || bus.o_free_count !== 3'd3) begin
            errors++; $display("FAIL entry_occ got occ=%b free=%0d exp 0100/3", bus.o_occupied, bus.o_free_count); end
        ev(0, 1, 2'd2, 11'd230);
        checks++; if (bus.o_occupied !== 4'b0000 || bus.o_free_count !== 3'd4) begin
            errors++; $display("FAIL exit_occ got occ=%b free=%0d exp 0000/4", bus.o_occupied, bus.o_free_count); end
        bc = 0;
        while (bus.o_busy === 1'b1 && bc < 200) begin bc++; tick(); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 4", bc); end
        checks++; if (bus.o_fee_valid !== 1'b1 || bus.o_fee !== 16'd30 || bus.o_fee_slot !== 2'd2) begin
            errors++; $display("FAIL basic_fee got fv=%b fee=%0d slot=%0d exp 1/30/2", bus.o_fee_valid, bus.o_fee, bus.o_fee_slot); end
        tick();
        checks++; if (bus.o_fee_valid !== 1'b0 || bus.o_fee !== 16'd30) begin
            errors++; $display("FAIL basic_hold got fv=%b fee=%0d exp 0/30", bus.o_fee_valid, bus.o_fee); end
    endtask

    task automatic test_wrap_grace();
        ev(1, 0, 2'd0, 11'd2040);
        ev(0, 1, 2'd0, 11'd5);
        checks++; if (bus.o_busy !== 1'b1 || bus.o_fee_valid !== 1'b0) begin
            errors++; $display("FAIL grace_e0 got busy=%b fv=%b exp 1/0", bus.o_busy, bus.o_fee_valid); end
        tick();
        checks++; if (bus.o_fee_valid !== 1'b1 || bus.o_fee !== 16'd0 || bus.o_fee_slot !== 2'd0 || bus.o_busy !== 1'b0) begin
            errors++; $display("FAIL grace_fee got fv=%b fee=%0d slot=%0d busy=%b exp 1/0/0/0",
                bus.o_fee_valid, bus.o_fee, bus.o_fee_slot, bus.o_busy); end
    endtask

    task automatic test_full_reject();
        for (int i = 0; i < 4; i++) ev(1, 0, 2'(i), 11'd10);
        checks++; if (bus.o_full !== 1'b1 || bus.o_free_count !== 3'd0 || bus.o_occupied !== 4'b1111) begin
            errors++; $display("FAIL full got full=%b free=%0d occ=%b exp 1/0/1111", bus.o_full, bus.o_free_count, bus.o_occupied); end
        ev(1, 0, 2'd1, 11'd500);
        checks++; if (bus.o_err !== 1'b1 || bus.o_occupied !== 4'b1111) begin
            errors++; $display("FAIL full_reject got err=%b occ=%b exp 1/1111", bus.o_err, bus.o_occupied); end
        tick();
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width got %b exp 0", bus.o_err); end
    endtask

    task automatic test_errors();
        int bc;
        // Stamp of slot 1 must still be 10 after the rejected entry at 500: dur 60 -> 1 unit.
        ev(0, 1, 2'd1, 11'd70);
        bc = 0;
        while (bus.o_busy === 1'b1 && bc < 200) begin bc++; tick(); end
        checks++; if (bc !== 2 || bus.o_fee_valid !== 1'b1 || bus.o_fee !== 16'd10 || bus.o_fee_slot !== 2'd1) begin
            errors++; $display("FAIL one_unit got cyc=%0d fv=%b fee=%0d slot=%0d exp 2/1/10/1", bc, bus.o_fee_valid, bus.o_fee, bus.o_fee_slot); end
        // dur exactly GRACE is free.
        ev(0, 1, 2'd3, 11'd25);
        tick();
        checks++; if (bus.o_fee_valid !== 1'b1 || bus.o_fee !== 16'd0 || bus.o_fee_slot !== 2'd3) begin
            errors++; $display("FAIL grace_edge got fv=%b fee=%0d slot=%0d exp 1/0/3", bus.o_fee_valid, bus.o_fee, bus.o_fee_slot); end
        ev(0, 1, 2'd3, 11'd30);
        checks++; if (bus.o_err !== 1'b1 || bus.o_busy !== 1'b0) begin
            errors++; $display("FAIL out_empty got err=%b busy=%b exp 1/0", bus.o_err, bus.o_busy); end
        ev(1, 1, 2'd3, 11'd30);
        checks++; if (bus.o_err !== 1'b1 || bus.o_occupied !== 4'b0101) begin
            errors++; $display("FAIL in_out_same got err=%b occ=%b exp 1/0101", bus.o_err, bus.o_occupied); end
        ev(1, 1, 2'd0, 11'd30);
        checks++; if (bus.o_err !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_occupied !== 4'b0101 || bus.o_free_count !== 3'd2) begin
            errors++; $display("FAIL in_out_occ got err=%b busy=%b occ=%b free=%0d exp 1/0/0101/2",
                bus.o_err, bus.o_busy, bus.o_occupied, bus.o_free_count); end
        tick();
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", bus.o_err); end
    endtask

    task automatic test_back_to_back();
        ev(1, 0, 2'd1, 11'd0);
        ev(0, 1, 2'd1, 11'd61);
        tick(); tick();
        ev(1, 0, 2'd3, 11'd0);
        checks++; if (bus.o_err !== 1'b1 || bus.o_fee_valid !== 1'b1 || bus.o_fee !== 16'd20 || bus.o_occupied !== 4'b0101) begin
            errors++; $display("FAIL finish_edge got err=%b fv=%b fee=%0d occ=%b exp 1/1/20/0101",
                bus.o_err, bus.o_fee_valid, bus.o_fee, bus.o_occupied); end
        ev(1, 0, 2'd3, 11'd0);
        checks++; if (bus.o_err !== 1'b0 || bus.o_occupied !== 4'b1101 || bus.o_free_count !== 3'd1) begin
            errors++; $display("FAIL fv_cycle_accept got err=%b occ=%b free=%0d exp 0/1101/1", bus.o_err, bus.o_occupied, bus.o_free_count); end
    endtask

    task automatic test_busy_reset();
        logic seen;
        ev(0, 1, 2'd0, 11'd600);
        ev(1, 0, 2'd1, 11'd600);
        checks++; if (bus.o_err !== 1'b1 || bus.o_occupied !== 4'b1100 || bus.o_busy !== 1'b1) begin
            errors++; $display("FAIL busy_reject got err=%b occ=%b busy=%b exp 1/1100/1", bus.o_err, bus.o_occupied, bus.o_busy); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (bus.o_occupied !== 4'b0000 || bus.o_free_count !== 3'd4 || bus.o_busy !== 1'b0 || bus.o_full !== 1'b0) begin
            errors++; $display("FAIL abort_state got occ=%b free=%0d busy=%b full=%b exp 0000/4/0/0",
                bus.o_occupied, bus.o_free_count, bus.o_busy, bus.o_full); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus.o_fee_valid === 1'b1) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0 || bus.o_fee !== 16'd0) begin
            errors++; $display("FAIL abort_no_fee got seen=%b fee=%0d exp 0/0", seen, bus.o_fee); end
    endtask

    task automatic test_dut5();
        int bc;
        ev5(1, 0, 3'd5, 11'd0);
        checks++; if (bus5.o_err !== 1'b1 || bus5.o_occupied !== 5'b00000) begin
            errors++; $display("FAIL id_range got err=%b occ=%b exp 1/00000", bus5.o_err, bus5.o_occupied); end
        ev5(0, 1, 3'd7, 11'd0);
        checks++; if (bus5.o_err !== 1'b1 || bus5.o_busy !== 1'b0) begin
            errors++; $display("FAIL id_range7 got err=%b busy=%b exp 1/0", bus5.o_err, bus5.o_busy); end
        ev5(1, 0, 3'd0, 11'd100);
        ev5(0, 1, 3'd0, 11'd116);
        tick();
        checks++; if (bus5.o_fee_valid !== 1'b0 || bus5.o_busy !== 1'b1) begin
            errors++; $display("FAIL grace_plus1_mid got fv=%b busy=%b exp 0/1", bus5.o_fee_valid, bus5.o_busy); end
        tick();
        checks++; if (bus5.o_fee_valid !== 1'b1 || bus5.o_fee !== 4'd10) begin
            errors++; $display("FAIL grace_plus1 got fv=%b fee=%0d exp 1/10", bus5.o_fee_valid, bus5.o_fee); end
        ev5(1, 0, 3'd4, 11'd0);
        checks++; if (bus5.o_occupied !== 5'b10000 || bus5.o_free_count !== 3'd4) begin
            errors++; $display("FAIL slot4_in got occ=%b free=%0d exp 10000/4", bus5.o_occupied, bus5.o_free_count); end
        ev5(0, 1, 3'd4, 11'd2000);
        bc = 0;
        while (bus5.o_busy === 1'b1 && bc < 200) begin bc++; tick(); end
        checks++; if (bc !== 35) begin errors++; $display("FAIL sat_latency got %0d exp 35", bc); end
        checks++; if (bus5.o_fee_valid !== 1'b1 || bus5.o_fee !== 4'd15 || bus5.o_fee_slot !== 3'd4) begin
            errors++; $display("FAIL saturate got fv=%b fee=%0d slot=%0d exp 1/15/4", bus5.o_fee_valid, bus5.o_fee, bus5.o_fee_slot); end
    endtask

    initial begin
        bus.i_car_in = 1'b0; bus.i_car_out = 1'b0; bus.i_slot_id = '0; bus.i_timer = '0;
        bus5.i_car_in = 1'b0; bus5.i_car_out = 1'b0; bus5.i_slot_id = '0; bus5.i_timer = '0;
        test_reset();
        test_basic_fee();
        test_wrap_grace();
        test_full_reject();
        test_errors();
        test_back_to_back();
        test_busy_reset();
        test_dut5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
